// File: rtl/pch_emu_pkg.sv
// Shared types for the PCH power-sequencing responder: state and error encodings,
// the CPLD response bundle and the chain ordering used for order checks.
package pch_emu_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_AUX_RAMP = 4'd1,
        ST_AUX_GOOD = 4'd2,
        ST_SLP_DLY  = 4'd3,
        ST_W_RSMRST = 4'd4,
        ST_W_SRST   = 4'd5,
        ST_W_PCHOK  = 4'd6,
        ST_W_SYSOK  = 4'd7,
        ST_S0       = 4'd8,
        ST_PWR_DN   = 4'd9,
        ST_ERROR    = 4'd10
    } pwr_state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_TO_RSMRST = 3'd1,
        ERR_TO_SRST   = 3'd2,
        ERR_TO_PCHOK  = 3'd3,
        ERR_TO_SYSOK  = 3'd4,
        ERR_ORDER     = 3'd5,
        ERR_TO_PWRDN  = 3'd6,
        ERR_S0_DROP   = 3'd7
    } err_code_e;

    // Chain order is bit order: RSMRST (bit 0) first, SYS_PWROK (bit 3) last.
    localparam int CHAIN_LEN = 4;

    typedef struct packed {
        logic sys_pwrok;
        logic pch_pwrok;
        logic srst_bmc_n;
        logic rsmrst_n;
    } cpld_rsp_t;

    // Signals that must still be low while waiting on chain step 'step'.
    function automatic logic [CHAIN_LEN-1:0] later_mask(input logic [1:0] step);
        return ~((CHAIN_LEN'(2) << step) - CHAIN_LEN'(1));
    endfunction

endpackage

// File: rtl/seq_delay_cnt.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module seq_delay_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pch_pwr_seq_responder.sv
// PCH/platform-VR emulator for the CPLD power-sequencing interface: ramps aux power-good,
// drives SLP_S4#/SLP_S3#, and checks the CPLD's RSMRST/SRST/PWROK responses.
module pch_pwr_seq_responder
    import pch_emu_pkg::*;
#(
    parameter int AUX_RAMP_CYCLES = 16,
    parameter int SLP_DLY_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 11
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_p1v8_aux_en,
    input  logic       i_pwr_req,
    input  logic       i_rsmrst_n,
    input  logic       i_srst_bmc_n,
    input  logic       i_pch_pwrok,
    input  logic       i_sys_pwrok,
    output logic       o_pwrgd_p1v8_aux,
    output logic       o_slp_s4_n,
    output logic       o_slp_s3_n,
    output logic [3:0] o_state,
    output logic       o_seq_done,
    output logic       o_err,
    output logic [2:0] o_err_code
);

    // Loaded with N-1 so a state holding N cycles of count advances on the N-th clock after entry.
    localparam logic [CNT_W-1:0] LD_AUX = CNT_W'((AUX_RAMP_CYCLES > 0) ? AUX_RAMP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] LD_SLP = CNT_W'((SLP_DLY_CYCLES > 0) ? SLP_DLY_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] LD_TMO = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    pwr_state_e           state, nxt;
    err_code_e            err_code, nxt_code;
    cpld_rsp_t            rsp;
    logic [CHAIN_LEN-1:0] chain;
    logic [1:0]           step;
    logic                 cnt_done, cnt_load;
    logic [CNT_W-1:0]     cnt_val;

    assign rsp   = '{sys_pwrok: i_sys_pwrok, pch_pwrok: i_pch_pwrok,
                     srst_bmc_n: i_srst_bmc_n, rsmrst_n: i_rsmrst_n};
    assign chain = rsp;
    assign step  = state[1:0];

    always_comb begin
        nxt      = state;
        nxt_code = ERR_NONE;
        if (!i_p1v8_aux_en)
            nxt = ST_OFF;
        else begin
            case (state)
                ST_OFF:      nxt = ST_AUX_RAMP;
                ST_AUX_RAMP: if (cnt_done) nxt = ST_AUX_GOOD;
                ST_AUX_GOOD: if (i_pwr_req) nxt = ST_SLP_DLY;
                ST_SLP_DLY: begin
                    if (!i_pwr_req)    nxt = ST_PWR_DN;
                    else if (cnt_done) nxt = ST_W_RSMRST;
                end
                ST_W_RSMRST, ST_W_SRST, ST_W_PCHOK, ST_W_SYSOK: begin
                    if (!i_pwr_req)
                        nxt = ST_PWR_DN;
                    else if (chain[step])
                        nxt = pwr_state_e'(state + 4'd1);
                    else if (cnt_done) begin
                        nxt      = ST_ERROR;
                        nxt_code = err_code_e'({1'b0, step} + 3'd1);
                    end else if ((chain & later_mask(step)) != '0) begin
                        nxt      = ST_ERROR;
                        nxt_code = ERR_ORDER;
                    end
                end
                ST_S0: begin
                    if (!i_pwr_req)
                        nxt = ST_PWR_DN;
                    else if (chain != '1) begin
                        nxt      = ST_ERROR;
                        nxt_code = ERR_S0_DROP;
                    end
                end
                ST_PWR_DN: begin
                    if (!rsp.pch_pwrok && !rsp.sys_pwrok)
                        nxt = ST_AUX_GOOD;
                    else if (cnt_done) begin
                        nxt      = ST_ERROR;
                        nxt_code = ERR_TO_PWRDN;
                    end
                end
                ST_ERROR:    nxt = ST_ERROR;
                default:     nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        cnt_val = '0;
        case (nxt)
            ST_AUX_RAMP: cnt_val = LD_AUX;
            ST_SLP_DLY:  cnt_val = LD_SLP;
            ST_W_RSMRST, ST_W_SRST, ST_W_PCHOK, ST_W_SYSOK, ST_PWR_DN: cnt_val = LD_TMO;
            default:     cnt_val = '0;
        endcase
    end

    assign cnt_load = (nxt != state);

    seq_delay_cnt #(.CNT_W(CNT_W)) u_dly (
        .clk      (clk),
        .rst_n    (resetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Outputs follow the state being entered; ERROR is only reachable with pwrgd already high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_OFF;
            err_code         <= ERR_NONE;
            o_pwrgd_p1v8_aux <= 1'b0;
            o_slp_s4_n       <= 1'b0;
            o_slp_s3_n       <= 1'b0;
            o_seq_done       <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            state            <= nxt;
            o_pwrgd_p1v8_aux <= !(nxt inside {ST_OFF, ST_AUX_RAMP});
            o_slp_s4_n       <= nxt inside {ST_SLP_DLY, ST_W_RSMRST, ST_W_SRST, ST_W_PCHOK,
                                            ST_W_SYSOK, ST_S0};
            o_slp_s3_n       <= nxt inside {ST_W_RSMRST, ST_W_SRST, ST_W_PCHOK, ST_W_SYSOK, ST_S0};
            o_seq_done       <= (nxt == ST_S0);
            o_err            <= (nxt == ST_ERROR);
            if (nxt != ST_ERROR)
                err_code <= ERR_NONE;
            else if (state != ST_ERROR)
                err_code <= nxt_code;
        end
    end

    assign o_state    = state;
    assign o_err_code = err_code;

endmodule
